// File: rtl/gfp8_nv_dot_seq_pkg.sv
// Shared types and widths for the gfp8_nv_dot sequencer: FSM states, result payload, issue tags.
package gfp8_nv_seq_pkg;
  localparam int MANT_W = 32;
  localparam int EXP_W  = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic signed [MANT_W-1:0] mantissa;
    logic signed [EXP_W-1:0]  exponent;
    logic                     last;
  } seq_result_t;

  // Travels alongside an operand pair through the dot unit's fixed latency.
  typedef struct packed {
    logic valid;
    logic last;
  } seq_tag_t;
endpackage

// File: rtl/gfp8_nv_dot_seq_if.sv
// Handshake bundle of the sequencer; perf counter ports exist only with GFP8_NV_DOT_SEQ_PERF_EN.
interface gfp8_nv_dot_seq_if;
  import gfp8_nv_seq_pkg::*;

  logic                     i_cmd_valid;
  logic                     o_cmd_ready;
  logic [CNT_W-1:0]         i_cmd_num_nv;
  logic                     i_nv_valid;
  logic                     o_nv_ready;
  logic                     o_dot_input_valid;
  logic signed [MANT_W-1:0] i_dot_mantissa;
  logic signed [EXP_W-1:0]  i_dot_exponent;
  logic                     o_res_valid;
  logic                     i_res_ready;
  logic [MANT_W-1:0]        o_res_mantissa;
  logic [EXP_W-1:0]         o_res_exponent;
  logic                     o_res_last;
  logic                     o_busy;
  logic                     o_done;
`ifdef GFP8_NV_DOT_SEQ_PERF_EN
  logic [31:0]              o_perf_busy_cycles;
  logic [31:0]              o_perf_stall_cycles;
`endif

  modport slave (
    input  i_cmd_valid, i_cmd_num_nv, i_nv_valid, i_dot_mantissa, i_dot_exponent, i_res_ready,
    output o_cmd_ready, o_nv_ready, o_dot_input_valid, o_res_valid, o_res_mantissa,
    output o_res_exponent, o_res_last, o_busy, o_done
`ifdef GFP8_NV_DOT_SEQ_PERF_EN
    , output o_perf_busy_cycles, o_perf_stall_cycles
`endif
  );

  modport master (
    output i_cmd_valid, i_cmd_num_nv, i_nv_valid, i_dot_mantissa, i_dot_exponent, i_res_ready,
    input  o_cmd_ready, o_nv_ready, o_dot_input_valid, o_res_valid, o_res_mantissa,
    input  o_res_exponent, o_res_last, o_busy, o_done
`ifdef GFP8_NV_DOT_SEQ_PERF_EN
    , input o_perf_busy_cycles, o_perf_stall_cycles
`endif
  );
endinterface

// File: rtl/gfp8_nv_result_fifo.sv
// Show-ahead result FIFO: RAM array with a registered head that bypasses a same-cycle write.
module gfp8_nv_result_fifo
  import gfp8_nv_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  seq_result_t              i_push_data,
  input  logic                     i_pop,
  output seq_result_t              o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  seq_result_t   mem [DEPTH];
  seq_result_t   head_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [CW-1:0] count_reg;
  logic          pop_ok;

  assign pop_ok      = i_pop && (count_reg != '0);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem[wr_ptr_reg] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      if (i_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      case ({i_push, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // The next head may be the word being written right now.
      if (i_push && (wr_ptr_reg == rd_ptr_next)) begin
        head_reg <= i_push_data;
      end else begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign o_head  = head_reg;
  assign o_empty = (count_reg == '0);
  assign o_count = count_reg;
endmodule

// File: rtl/gfp8_nv_dot_seq.sv
// Issue sequencer for one gfp8_nv_dot unit with latency tag tracking and a credit-protected result FIFO.
// Optional perf counters are enabled by defining GFP8_NV_DOT_SEQ_PERF_EN.
module gfp8_nv_dot_seq
  import gfp8_nv_seq_pkg::*;
#(
  parameter int DOT_LATENCY = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input logic                i_clk,
  input logic                i_reset,
  gfp8_nv_dot_seq_if.slave   bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  seq_state_t    state_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic [CW-1:0] inflight_reg;
  seq_tag_t      tag_reg [DOT_LATENCY];
  logic          busy_reg;
  logic          done_reg;

  logic          cmd_ready;
  logic          cmd_fire;
  logic          nv_ready;
  logic          issue;
  logic          retire;
  logic [CW:0]   credit_used;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_pop;
  seq_result_t   fifo_head;
  seq_result_t   push_data;

  assign cmd_ready = (state_reg == IDLE) && !i_reset;
  assign cmd_fire  = bus.i_cmd_valid && cmd_ready;

  // Credits ignore a same-cycle pop so buffered plus in-flight never exceeds the FIFO.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_reg};
  assign nv_ready    = (state_reg == RUN) && (remaining_reg != '0) && (credit_used < DEPTH_LIM);
  assign issue       = bus.i_nv_valid && nv_ready;
  assign retire      = tag_reg[DOT_LATENCY-1].valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DOT_LATENCY; i++) begin
        tag_reg[i] <= '0;
      end
      inflight_reg <= '0;
    end else begin
      tag_reg[0] <= '{valid: issue, last: issue && (remaining_reg == CNT_W'(1))};
      for (int i = 1; i < DOT_LATENCY; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
      case ({issue, retire})
        2'b10:   inflight_reg <= inflight_reg + CW'(1);
        2'b01:   inflight_reg <= inflight_reg - CW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            remaining_reg <= bus.i_cmd_num_nv;
            if (bus.i_cmd_num_nv == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            remaining_reg <= remaining_reg - CNT_W'(1);
          end
          if ((remaining_reg == '0) || (issue && (remaining_reg == CNT_W'(1)))) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if ((inflight_reg == '0) && fifo_empty) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign push_data = '{mantissa: bus.i_dot_mantissa,
                       exponent: bus.i_dot_exponent,
                       last:     tag_reg[DOT_LATENCY-1].last};
  assign fifo_pop  = !fifo_empty && bus.i_res_ready;

  gfp8_nv_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (retire),
    .i_push_data (push_data),
    .i_pop       (fifo_pop),
    .o_head      (fifo_head),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  assign bus.o_cmd_ready       = cmd_ready;
  assign bus.o_nv_ready        = nv_ready;
  assign bus.o_dot_input_valid = issue;
  assign bus.o_res_valid       = !fifo_empty;
  assign bus.o_res_mantissa    = fifo_head.mantissa;
  assign bus.o_res_exponent    = fifo_head.exponent;
  assign bus.o_res_last        = fifo_head.last;
  assign bus.o_busy            = busy_reg;
  assign bus.o_done            = done_reg;

`ifdef GFP8_NV_DOT_SEQ_PERF_EN
  logic [31:0] perf_busy_reg;
  logic [31:0] perf_stall_reg;
  logic        stall;

  assign stall = (state_reg == RUN) && bus.i_nv_valid && !nv_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      perf_busy_reg  <= '0;
      perf_stall_reg <= '0;
    end else if (cmd_fire) begin
      perf_busy_reg  <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (busy_reg && (perf_busy_reg != '1)) begin
        perf_busy_reg <= perf_busy_reg + 32'd1;
      end
      if (stall && (perf_stall_reg != '1)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign bus.o_perf_busy_cycles  = perf_busy_reg;
  assign bus.o_perf_stall_cycles = perf_stall_reg;
`endif
endmodule
